// File: rtl/wshbn_arbiter_2m.sv
// Two-master Wishbone arbiter sharing one RAM slave (M0 = I-cache, M1 = D-cache).
// Define WSHBN_ARB_RR_EN for round-robin on contention; default is fixed M0 priority.
`timescale 1ns/1ps

module wshbn_arbiter_2m #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic [ADDR_WIDTH-1:0] M0_ADR_I,
    input  logic [WORD_WIDTH-1:0] M0_DAT_I,
    input  logic                  M0_WE_I,
    input  logic                  M0_STB_I,
    input  logic                  M0_CYC_I,
    output logic [WORD_WIDTH-1:0] M0_DAT_O,
    output logic                  M0_ACK_O,
    input  logic [ADDR_WIDTH-1:0] M1_ADR_I,
    input  logic [WORD_WIDTH-1:0] M1_DAT_I,
    input  logic                  M1_WE_I,
    input  logic                  M1_STB_I,
    input  logic                  M1_CYC_I,
    output logic [WORD_WIDTH-1:0] M1_DAT_O,
    output logic                  M1_ACK_O,
    output logic [ADDR_WIDTH-1:0] S_ADR_O,
    output logic [WORD_WIDTH-1:0] S_DAT_O,
    output logic                  S_WE_O,
    output logic                  S_STB_O,
    output logic                  S_CYC_O,
    input  logic [WORD_WIDTH-1:0] S_DAT_I,
    input  logic                  S_ACK_I,
    output logic [1:0]            GNT_O
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam logic [1:0] OWN_M0 = 2'b01;
    localparam logic [1:0] OWN_M1 = 2'b10;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_last_owner;
    logic       w_contest_m1;

`ifdef WSHBN_ARB_RR_EN
    // On contention, favour whichever master did not own the bus last.
    assign w_contest_m1 = (r_last_owner == OWN_M0);
`else
    // Fixed priority: M0 always wins; last_owner is tracked but not consulted.
    assign w_contest_m1 = 1'b0;
    logic w_unused_last;
    assign w_unused_last = ^r_last_owner;
`endif

    // Next-state: grants are held for the whole cycle and handed over directly.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I)
                    w_next = w_contest_m1 ? GNT1 : GNT0;
                else if (M0_CYC_I)
                    w_next = GNT0;
                else if (M1_CYC_I)
                    w_next = GNT1;
            end
            GNT0: begin
                if (!M0_CYC_I)
                    w_next = M1_CYC_I ? GNT1 : IDLE;
            end
            GNT1: begin
                if (!M1_CYC_I)
                    w_next = M0_CYC_I ? GNT0 : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // State register; reset drops any transfer in flight.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Remember the master granted most recently, captured on grant entry.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_last_owner <= OWN_M1;
        end else if (w_next != r_state) begin
            if (w_next == GNT0)
                r_last_owner <= OWN_M0;
            else if (w_next == GNT1)
                r_last_owner <= OWN_M1;
        end
    end

    // Route the owner onto the slave and the slave response back to the
    // owner only; routing follows the registered state, so an ack in the
    // owner's final cycle never leaks to the next owner.
    always_comb begin
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        S_WE_O   = 1'b0;
        S_STB_O  = 1'b0;
        S_CYC_O  = 1'b0;
        M0_DAT_O = '0;
        M0_ACK_O = 1'b0;
        M1_DAT_O = '0;
        M1_ACK_O = 1'b0;
        case (r_state)
            GNT0: begin
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                S_WE_O   = M0_WE_I;
                S_STB_O  = M0_STB_I;
                S_CYC_O  = M0_CYC_I;
                M0_DAT_O = S_DAT_I;
                M0_ACK_O = S_ACK_I;
            end
            GNT1: begin
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                S_WE_O   = M1_WE_I;
                S_STB_O  = M1_STB_I;
                S_CYC_O  = M1_CYC_I;
                M1_DAT_O = S_DAT_I;
                M1_ACK_O = S_ACK_I;
            end
            default: ;
        endcase
    end

    assign GNT_O = r_state;

endmodule

// File: tb/tb_wshbn_arbiter_2m.sv
// Self-checking bench for wshbn_arbiter_2m.
// Per-cycle expectations go to a scoreboard queue and are compared on sampling.
`timescale 1ns/1ps

module tb_wshbn_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;

    // Row bits: {c0, s0, w0, c1, s1, w1, sack, gnt[1:0]}
    typedef struct packed {
        logic       c0;
        logic       s0;
        logic       w0;
        logic       c1;
        logic       s1;
        logic       w1;
        logic       sack;
        logic [1:0] gnt;
    } vec_t;

    typedef struct packed {
        logic [1:0]    gnt;
        logic          s_cyc;
        logic          s_stb;
        logic          s_we;
        logic [AW-1:0] s_adr;
        logic [DW-1:0] s_dat;
        logic          m0_ack;
        logic          m1_ack;
        logic [DW-1:0] m0_dat;
        logic [DW-1:0] m1_dat;
    } bus_t;

    logic          CLK_I = 1'b0;
    logic          RST_NI = 1'b0;
    logic [AW-1:0] M0_ADR_I = '0;
    logic [DW-1:0] M0_DAT_I = '0;
    logic          M0_WE_I = 1'b0;
    logic          M0_STB_I = 1'b0;
    logic          M0_CYC_I = 1'b0;
    logic [DW-1:0] M0_DAT_O;
    logic          M0_ACK_O;
    logic [AW-1:0] M1_ADR_I = '0;
    logic [DW-1:0] M1_DAT_I = '0;
    logic          M1_WE_I = 1'b0;
    logic          M1_STB_I = 1'b0;
    logic          M1_CYC_I = 1'b0;
    logic [DW-1:0] M1_DAT_O;
    logic          M1_ACK_O;
    logic [AW-1:0] S_ADR_O;
    logic [DW-1:0] S_DAT_O;
    logic          S_WE_O;
    logic          S_STB_O;
    logic          S_CYC_O;
    logic [DW-1:0] S_DAT_I = '0;
    logic          S_ACK_I = 1'b0;
    logic [1:0]    GNT_O;

    int   n_vec = 0;
    int   n_err = 0;
    int   nrow = 0;
    bus_t sb [$];
    bus_t obs;

    wshbn_arbiter_2m #(
        .ADDR_WIDTH(AW),
        .WORD_WIDTH(DW)
    ) dut (
        .CLK_I   (CLK_I),
        .RST_NI  (RST_NI),
        .M0_ADR_I(M0_ADR_I),
        .M0_DAT_I(M0_DAT_I),
        .M0_WE_I (M0_WE_I),
        .M0_STB_I(M0_STB_I),
        .M0_CYC_I(M0_CYC_I),
        .M0_DAT_O(M0_DAT_O),
        .M0_ACK_O(M0_ACK_O),
        .M1_ADR_I(M1_ADR_I),
        .M1_DAT_I(M1_DAT_I),
        .M1_WE_I (M1_WE_I),
        .M1_STB_I(M1_STB_I),
        .M1_CYC_I(M1_CYC_I),
        .M1_DAT_O(M1_DAT_O),
        .M1_ACK_O(M1_ACK_O),
        .S_ADR_O (S_ADR_O),
        .S_DAT_O (S_DAT_O),
        .S_WE_O  (S_WE_O),
        .S_STB_O (S_STB_O),
        .S_CYC_O (S_CYC_O),
        .S_DAT_I (S_DAT_I),
        .S_ACK_I (S_ACK_I),
        .GNT_O   (GNT_O)
    );

    always #5 CLK_I = ~CLK_I;

    assign obs = {GNT_O, S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O,
                  M0_ACK_O, M1_ACK_O, M0_DAT_O, M1_DAT_O};

    // Expected bus view for a cycle whose owner is given by v.gnt.
    function automatic bus_t model(input vec_t v);
        bus_t b;
        b = '0;
        b.gnt = v.gnt;
        if (v.gnt == 2'b01) begin
            b.s_cyc  = v.c0;
            b.s_stb  = v.s0;
            b.s_we   = v.w0;
            b.s_adr  = M0_ADR_I;
            b.s_dat  = M0_DAT_I;
            b.m0_ack = v.sack;
            b.m0_dat = S_DAT_I;
        end else if (v.gnt == 2'b10) begin
            b.s_cyc  = v.c1;
            b.s_stb  = v.s1;
            b.s_we   = v.w1;
            b.s_adr  = M1_ADR_I;
            b.s_dat  = M1_DAT_I;
            b.m1_ack = v.sack;
            b.m1_dat = S_DAT_I;
        end
        return b;
    endfunction

    task automatic drive(input vec_t v, input logic [DW-1:0] sd);
        nrow++;
        M0_CYC_I = v.c0;
        M0_STB_I = v.s0;
        M0_WE_I  = v.w0;
        M1_CYC_I = v.c1;
        M1_STB_I = v.s1;
        M1_WE_I  = v.w1;
        S_ACK_I  = v.sack;
        S_DAT_I  = sd;
        M0_ADR_I = 32'h0000_0010;
        M1_ADR_I = 32'h0000_0020;
        M0_DAT_I = 32'hA0A0_0000 | 32'(nrow);
        M1_DAT_I = 32'hB0B0_0000 | 32'(nrow);
    endtask

    task automatic test_reset;
        vec_t tbl [3] = '{9'b110_110_1_00, 9'b110_110_1_00,
                          9'b000_000_0_00};
        bus_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_I);
            if (i == 2) RST_NI = 1'b1;
            drive(tbl[i], $urandom);
            sb.push_back(model(tbl[i]));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs.gnt !== e.gnt) begin
                n_err++;
                $display("FAIL reset gnt row %0d: got %b want %b",
                         i, obs.gnt, e.gnt);
            end
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL reset bus row %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_single_read;
        vec_t tbl [5] = '{9'b110_000_0_00, 9'b110_000_0_01,
                          9'b110_000_1_01, 9'b000_000_0_01,
                          9'b000_000_0_00};
        bus_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_I);
            drive(tbl[i], $urandom);
            sb.push_back(model(tbl[i]));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs.gnt !== e.gnt) begin
                n_err++;
                $display("FAIL single_read gnt row %0d: got %b want %b",
                         i, obs.gnt, e.gnt);
            end
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL single_read bus row %0d: got %h want %h",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_hold_handover;
        vec_t tbl [10] = '{9'b110_000_0_00, 9'b110_000_0_01,
                           9'b110_111_0_01, 9'b110_111_0_01,
                           9'b110_111_1_01, 9'b110_111_0_01,
                           9'b000_111_0_01, 9'b000_111_1_10,
                           9'b000_000_0_10, 9'b000_000_0_00};
        bus_t e;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_I);
            drive(tbl[i], $urandom);
            sb.push_back(model(tbl[i]));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs.gnt !== e.gnt) begin
                n_err++;
                $display("FAIL handover gnt row %0d: got %b want %b",
                         i, obs.gnt, e.gnt);
            end
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL handover bus row %0d: got %h want %h",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_contested_rounds;
        vec_t tbl [7] = '{9'b110_110_0_00, 9'b110_110_0_01,
                          9'b110_110_1_01, 9'b000_110_0_01,
                          9'b000_110_0_10, 9'b000_110_1_10,
                          9'b000_000_0_10};
        vec_t tail = 9'b000_000_0_00;
        bus_t e;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 7; i++) begin
                if (r == 3 && i > 0) break;
                @(negedge CLK_I);
                if (r == 3) begin
                    drive(tail, $urandom);
                    sb.push_back(model(tail));
                end else begin
                    drive(tbl[i], $urandom);
                    sb.push_back(model(tbl[i]));
                end
                #2;
                e = sb.pop_front();
                n_vec++;
                if (obs.gnt !== e.gnt) begin
                    n_err++;
                    $display("FAIL contested gnt round %0d row %0d: got %b want %b",
                             r, i, obs.gnt, e.gnt);
                end
                n_vec++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL contested bus round %0d row %0d: got %h want %h",
                             r, i, obs, e);
                end
            end
        end
    endtask

    task automatic test_priority;
        vec_t tbl [9];
        bus_t e;
`ifdef WSHBN_ARB_RR_EN
        tbl = '{9'b110_000_0_00, 9'b110_000_1_01, 9'b000_000_0_01,
                9'b110_110_0_00, 9'b110_110_0_10, 9'b110_000_0_10,
                9'b110_000_0_01, 9'b000_000_0_01, 9'b000_000_0_00};
`else
        tbl = '{9'b110_000_0_00, 9'b110_000_1_01, 9'b000_000_0_01,
                9'b110_110_0_00, 9'b110_110_0_01, 9'b000_110_0_01,
                9'b000_110_0_10, 9'b000_000_0_10, 9'b000_000_0_00};
`endif
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK_I);
            drive(tbl[i], $urandom);
            sb.push_back(model(tbl[i]));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs.gnt !== e.gnt) begin
                n_err++;
                $display("FAIL priority gnt row %0d: got %b want %b",
                         i, obs.gnt, e.gnt);
            end
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL priority bus row %0d: got %h want %h",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_ack_on_drop;
        vec_t tbl [6] = '{9'b110_000_0_00, 9'b110_110_0_01,
                          9'b000_110_1_01, 9'b000_110_0_10,
                          9'b000_000_0_10, 9'b000_000_0_00};
        bus_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK_I);
            drive(tbl[i], (i == 2) ? 32'hDEAD_BEEF : $urandom);
            sb.push_back(model(tbl[i]));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs.gnt !== e.gnt) begin
                n_err++;
                $display("FAIL ack_drop gnt row %0d: got %b want %b",
                         i, obs.gnt, e.gnt);
            end
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL ack_drop bus row %0d: got %h want %h",
                         i, obs, e);
            end
        end
    endtask

    task automatic test_async_reset;
        vec_t wr   = 9'b000_111_0_10;
        vec_t wr0  = 9'b000_111_0_00;
        vec_t rsta = 9'b000_111_0_00;
        vec_t tbl [5] = '{9'b110_110_0_00, 9'b110_110_0_00,
                          9'b110_110_0_01, 9'b000_000_0_01,
                          9'b000_000_0_00};
        bus_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_I);
            drive((i == 0) ? wr0 : wr, $urandom);
            sb.push_back(model((i == 0) ? wr0 : wr));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL async_rst write row %0d: got %h want %h",
                         i, obs, e);
            end
        end
        #1 RST_NI = 1'b0;
        sb.push_back(model(rsta));
        #1;
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL async_rst drop: got %h want %h", obs, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK_I);
            if (i == 1) RST_NI = 1'b1;
            drive(tbl[i], $urandom);
            sb.push_back(model(tbl[i]));
            #2;
            e = sb.pop_front();
            n_vec++;
            if (obs.gnt !== e.gnt) begin
                n_err++;
                $display("FAIL async_rst gnt row %0d: got %b want %b",
                         i, obs.gnt, e.gnt);
            end
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL async_rst bus row %0d: got %h want %h",
                         i, obs, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_hold_handover();
        test_contested_rounds();
        test_priority();
        test_ack_on_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wshbn_arbiter_2m.md
WSHBN_ARBITER_2M -- requirements
Module: wshbn_arbiter_2m

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, Wishbone data width.
REQ-003 SHALL have port CLK_I  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_NI  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports M0_ADR_I  in  ADR_WIDTH and M1_ADR_I  in  ADDR_WIDTH, master 0 (instruction cache) and master 1 (data cache) addresses.
REQ-006 SHALL have ports M0_DAT_I and M1_DAT_I  in  WORD_WIDTH  master write data.
REQ-007 SHALL have ports M0_WE_I, M0_STB_I, M0_CYC_I, M1_WE_I, M1_STB_I, M1_CYC_I  in  1  master write enable, strobe and cycle.
REQ-008 SHALL have ports M0_DAT_O and M1_DAT_O  out  WORD_WIDTH  read data returned to each master.
REQ-009 SHALL have ports M0_ACK_O and M1_ACK_O  out  1  acknowledge to each master.
REQ-010 SHALL have ports S_ADR_O  out  ADDR_WIDTH and S_DAT_O  out  WORD_WIDTH  address and write data to the shared RAM slave.
REQ-011 SHALL have ports S_WE_O, S_STB_O, S_CYC_O  out  1  slave write enable, strobe and cycle.
REQ-012 SHALL have ports S_DAT_I  in  WORD_WIDTH and S_ACK_I  in  1  slave read data and acknowledge.
REQ-013 SHALL have port GNT_O  out  2  one-hot current owner (bit0 = M0, bit1 = M1, 00 = none).

Function
REQ-014 SHALL implement a registered FSM with states IDLE, GNT0, GNT1; GNT_O = 00/01/10 respectively.
REQ-015 IDLE: if any Mx_CYC_I is high, next state = GNTx chosen per REQ-020; otherwise stay IDLE; arbitration latency is one cycle from CYC rise to grant.
REQ-016 GNTx: while Mx_CYC_I is high, stay GNTx; the grant is never preempted mid-cycle.
REQ-017 GNTx with Mx_CYC_I low: next state = GNTy if the other master's CYC_I is high (handover without an IDLE bubble), else IDLE.
REQ-018 In GNTx, S_ADR_O, S_DAT_O, S_WE_O, S_STB_O and S_CYC_O SHALL equal master x's inputs combinationally; Mx_ACK_O = S_ACK_I and Mx_DAT_O = S_DAT_I.
REQ-019 The non-owner master and both masters in IDLE SHALL see ACK_O = 0 and DAT_O = 0; in IDLE, all S_* outputs = 0.
REQ-020 Simultaneous requests in IDLE or at handover SHALL resolve per REQ-026/REQ-027; a single requester always wins.
REQ-021 An S_ACK_I arriving in the same cycle the owner drops CYC SHALL still be routed to the owner only; it is never routed to the next owner.
REQ-022 A 2-bit last_owner register SHALL update to x on every entry to GNTx.

Reset
REQ-023 RST_NI low SHALL immediately force state = IDLE, GNT_O = 00, all S_* outputs = 0, all Mx_ACK_O/DAT_O = 0, last_owner = M1; this holds even mid-transfer.
REQ-024 After RST_NI deassertion, the first arbitration SHALL occur on the first rising edge with a CYC request.

Configuration
REQ-025 The block SHALL use macro WSHBN_ARB_RR_EN.
REQ-026 With WSHBN_ARB_RR_EN defined: on a simultaneous request, the grant goes to the master that is not last_owner (round-robin).
REQ-027 Without WSHBN_ARB_RR_EN: M0 always wins a simultaneous request (fixed priority); last_owner is kept but unused.

Verification
REQ-028 Single M0 read ADR=0x10 in IDLE -> GNT_O=01 next cycle, S_ADR_O=0x10, M0_ACK_O follows S_ACK_I, M1_ACK_O=0 throughout.
REQ-029 M0 holds CYC for 6 cycles while M1 requests at cycle 2 -> M1 is not granted until the cycle after M0_CYC_I falls; GNT_O goes 01->10 with no 00 cycle.
REQ-030 Both CYC rise together three times, each held 2 cycles, with RR_EN defined -> grants M0,M1,M0,M1,M0,M1; without it -> M0 wins every contested arbitration.
REQ-031 S_ACK_I=1 with S_DAT_I=0xDEADBEEF in the cycle M0 drops CYC while M1 waits -> M0_DAT_O=0xDEADBEEF and M0_ACK_O=1, M1_ACK_O=0.
REQ-032 RST_NI pulsed low during a GNT1 write -> S_CYC_O, S_STB_O, S_WE_O drop low asynchronously and GNT_O=00; the next contested request is granted to M0.
